paralelo_serial: RTL and testbench



---
 rtl/paralelo_serial.sv | 113 +++++++++++
 tb/tb_paralelo_serial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: bytes in through valid/ready and a one-entry
// holding register, MSB-first serial out, COM symbols during init and idle.
module paralelo_serial #(
    parameter logic [7:0]  COM      = 8'hBC,
    parameter int unsigned INIT_COM = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       data_out,
    output logic       active
);

    localparam int unsigned        CNT_W    = (INIT_COM > 1) ? $clog2(INIT_COM) : 1;
    localparam logic [CNT_W-1:0]   LAST_COM = CNT_W'(INIT_COM - 1);
    localparam logic [2:0]         LAST_BIT = 3'd7;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [7:0]       r_sr;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_com_cnt;
    logic [7:0]       r_hold;
    logic             r_hold_valid;
    logic             r_active;

    logic [0:0]       w_state;
    logic [7:0]       w_sr;
    logic [2:0]       w_bit_cnt;
    logic [CNT_W-1:0] w_com_cnt;
    logic [7:0]       w_hold;
    logic             w_hold_valid;
    logic             w_active;
    logic             w_accept;

    assign ready    = r_active & ~r_hold_valid;
    assign data_out = r_sr[7];
    assign active   = r_active;
    assign w_accept = valid_in & ready;

    // State register; reset aborts the current symbol and restarts init.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state      <= S_INIT;
            r_sr         <= COM;
            r_bit_cnt    <= 3'd0;
            r_com_cnt    <= '0;
            r_hold       <= 8'h00;
            r_hold_valid <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_sr         <= w_sr;
            r_bit_cnt    <= w_bit_cnt;
            r_com_cnt    <= w_com_cnt;
            r_hold       <= w_hold;
            r_hold_valid <= w_hold_valid;
            r_active     <= w_active;
        end
    end

    // Next-state: accept into hold, shift, and pick the next symbol at bit 7.
    always_comb begin
        w_state      = r_state;
        w_sr         = r_sr;
        w_bit_cnt    = r_bit_cnt;
        w_com_cnt    = r_com_cnt;
        w_hold       = r_hold;
        w_hold_valid = r_hold_valid;
        w_active     = r_active;

        // ready excludes a full hold, so this never collides with a drain below
        if (w_accept) begin
            w_hold       = data_in;
            w_hold_valid = 1'b1;
        end

        if (r_bit_cnt != LAST_BIT) begin
            w_sr      = {r_sr[6:0], 1'b0};
            w_bit_cnt = r_bit_cnt + 3'd1;
        end else begin
            w_bit_cnt = 3'd0;
            case (r_state)
                S_INIT: begin
                    w_sr = COM;
                    if (r_com_cnt == LAST_COM) begin
                        w_state  = S_RUN;
                        w_active = 1'b1;
                    end else begin
                        w_com_cnt = r_com_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (r_hold_valid) begin
                        w_sr         = r_hold;
                        w_hold_valid = 1'b0;
                    end else begin
                        w_sr = COM;
                    end
                end
                default: begin
                    w_state = S_INIT;
                    w_sr    = COM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: init/idle COM fill, single byte,
// back-to-back stream, early valid, reset mid-byte and a 3-byte send.
module tb_paralelo_serial;

    localparam logic [7:0] COM = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready;
    logic       data_out;
    logic       active;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         edge_n   = 0;
    int         n_acc    = 0;
    int         acc_edge = -1;
    int         mode     = 0;   // 0: hold inputs, 1: drop valid on accept, 2: increment data on accept
    logic [7:0] rx       = 8'h00;

    paralelo_serial #(.COM(COM), .INIT_COM(4)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (data_in),
        .valid_in(valid_in),
        .ready   (ready),
        .data_out(data_out),
        .active  (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock, entered and left at a falling edge; collects the serial bit.
    task automatic cyc();
        logic b;
        logic acc;
        int   e;
        b   = data_out;
        acc = (valid_in & ready) === 1'b1;
        e   = edge_n;
        @(posedge clk_32f);
        edge_n++;
        @(negedge clk_32f);
        rx = {rx[6:0], b};
        if (acc) begin
            n_acc++;
            if (acc_edge < 0) acc_edge = e;
            if (mode == 1) valid_in = 1'b0;
            if (mode == 2) data_in = data_in + 8'd1;
        end
    endtask

    task automatic read_sym();
        repeat (8) cyc();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cyc();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        @(negedge clk_32f);

        // Reset then idle
        do_reset(3);
        chk("rst_data_out", 32'(data_out), 32'd1);
        chk("rst_ready",    32'(ready),    32'd0);
        chk("rst_active",   32'(active),   32'd0);
        for (int k = 0; k < 3; k++) begin
            read_sym();
            chk($sformatf("init_sym%0d", k), 32'(rx), 32'(COM));
        end
        chk("active_before_31", 32'(active), 32'd0);
        chk("ready_before_31",  32'(ready),  32'd0);
        read_sym();
        chk("init_sym3",       32'(rx),     32'(COM));
        chk("active_after_31", 32'(active), 32'd1);
        chk("ready_after_31",  32'(ready),  32'd1);
        for (int k = 4; k < 8; k++) begin
            read_sym();
            chk($sformatf("idle_sym%0d", k), 32'(rx), 32'(COM));
        end
        chk("idle_ready", 32'(ready), 32'd1);

        // Single byte 0xA5 offered at edge 64
        n_acc = 0; mode = 1; data_in = 8'hA5; valid_in = 1'b1;
        cyc();
        chk("single_ready_drop", 32'(ready), 32'd0);
        repeat (7) cyc();
        chk("single_pre_com",  32'(rx),    32'(COM));
        read_sym();
        chk("single_byte",     32'(rx),    32'hA5);
        chk("single_ready_ret", 32'(ready), 32'd1);
        read_sym();
        chk("single_post_com", 32'(rx),    32'(COM));
        chk("single_acc_cnt",  32'(n_acc), 32'd1);

        // Back-to-back stream 0x01, 0x02, ...
        n_acc = 0; mode = 2; data_in = 8'h01; valid_in = 1'b1;
        read_sym();
        chk("stream_lead_com", 32'(rx), 32'(COM));
        for (int k = 1; k <= 3; k++) begin
            read_sym();
            chk($sformatf("stream_byte%0d", k), 32'(rx), 32'(k));
        end
        chk("stream_acc_cnt", 32'(n_acc), 32'd4);
        valid_in = 1'b0; mode = 0;
        read_sym();
        chk("stream_byte4",    32'(rx), 32'h04);
        read_sym();
        chk("stream_tail_com", 32'(rx), 32'(COM));

        // Early valid: 0x3C offered from edge 0
        do_reset(2);
        n_acc = 0; acc_edge = -1; mode = 1; data_in = 8'h3C; valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            read_sym();
            chk($sformatf("early_init_sym%0d", k), 32'(rx), 32'(COM));
        end
        chk("early_no_acc_init", 32'(n_acc), 32'd0);
        read_sym();
        chk("early_sym4", 32'(rx), 32'(COM));
        read_sym();
        chk("early_sym5", 32'(rx), 32'h3C);
        chk("early_acc_edge", 32'(acc_edge), 32'd32);
        read_sym();
        chk("early_sym6", 32'(rx), 32'(COM));

        // Reset mid-byte: 0x0F shifting, 0xFF held, reset at bit 3
        data_in = 8'h0F; valid_in = 1'b1; mode = 1;
        read_sym();
        chk("mid_sym7", 32'(rx), 32'(COM));
        data_in = 8'hFF; valid_in = 1'b1; mode = 1;
        repeat (3) cyc();
        chk("mid_0f_msbs",  32'(rx[2:0]),  32'd0);
        chk("mid_bit3_val", 32'(data_out), 32'd0);
        chk("mid_hold_full", 32'(ready),   32'd0);
        reset = 1'b1;
        cyc();
        chk("mid_rst_active",   32'(active),   32'd0);
        chk("mid_rst_ready",    32'(ready),    32'd0);
        chk("mid_rst_data_out", 32'(data_out), 32'd1);
        do_reset(1);
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            read_sym();
            chk($sformatf("mid_after_sym%0d", k), 32'(rx), 32'(COM));
        end
        chk("mid_no_acc", 32'(n_acc), 32'd0);

        // Three bytes 0x11, 0x22, 0x33 sent back to back
        n_acc = 0; mode = 0; data_in = 8'h11; valid_in = 1'b1;
        cyc();
        data_in = 8'h22;
        repeat (7) cyc();
        chk("tx_lead_com", 32'(rx), 32'(COM));
        cyc();
        data_in = 8'h33;
        repeat (7) cyc();
        chk("tx_byte11", 32'(rx), 32'h11);
        cyc();
        valid_in = 1'b0;
        repeat (7) cyc();
        chk("tx_byte22", 32'(rx), 32'h22);
        read_sym();
        chk("tx_byte33", 32'(rx), 32'h33);
        read_sym();
        chk("tx_tail_com", 32'(rx), 32'(COM));
        chk("tx_acc_cnt", 32'(n_acc), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
